// File: rtl/demux8_deserializer_pkg.sv
// rtl/demux8_deserializer_pkg.sv - shared widths and output-register state for the deserializer
// Contents: WORD_W (parallel word width), IDX_W (bit-slot index width), out_state_e (EMPTY/FULL).
package demux8_deserializer_pkg;

    localparam int WORD_W = 8;
    localparam int IDX_W  = 3;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/demux8_deserializer_demux1_to_8.sv
// rtl/demux8_deserializer_demux1_to_8.sv - combinational 1-to-8 demux producing write strobes and data
// Ports:
//   i_bit    - serial bit to be steered
//   i_sel    - destination slot
//   i_en     - write enable; strobes are all zero when low
//   o_strobe - one-hot per-slot write enable
//   o_data   - i_bit placed in the selected slot, zero elsewhere
module demux1_to_8
    import demux8_deserializer_pkg::*;
(
    input  logic              i_bit,
    input  logic [IDX_W-1:0]  i_sel,
    input  logic              i_en,
    output logic [WORD_W-1:0] o_strobe,
    output logic [WORD_W-1:0] o_data
);

    always_comb begin
        o_strobe = '0;
        if (i_en) begin
            o_strobe[i_sel] = 1'b1;
        end
        o_data = {WORD_W{i_bit}} & o_strobe;
    end

endmodule

// File: rtl/demux8_deserializer.sv
// rtl/demux8_deserializer.sv - serial-to-parallel 8-bit deserializer with frame sync and ready/valid handshakes
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   in_bit/in_valid    - serial input stream; in_ready back-pressures it
//   frame_sync         - with an accepted bit, marks that bit as bit 0 of a new word
//   out/out_valid      - assembled word; out_ready consumes it
//   sel                - next bit slot to be written (0..7)
//   sync_err           - one-cycle pulse when frame_sync discarded a partial word
module demux8_deserializer
    import demux8_deserializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_bit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              frame_sync,
    output logic [WORD_W-1:0] out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  sel,
    output logic              sync_err
);

    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(WORD_W - 1);

    logic [IDX_W-1:0]  r_sel;
    logic [WORD_W-1:0] r_asm;
    logic [WORD_W-1:0] r_out;
    out_state_e        r_state;
    logic              r_sync_err;

    logic              w_full;
    logic              w_in_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_complete;
    logic [IDX_W-1:0]  w_slot;
    logic [IDX_W-1:0]  w_wr_sel;
    logic [WORD_W-1:0] w_strobe;
    logic [WORD_W-1:0] w_data;
    logic [WORD_W-1:0] w_asm_base;
    logic [WORD_W-1:0] w_asm_next;

    assign w_full = (r_state == OUT_FULL);

    // Only the last bit of a word can be blocked: it needs a free output
    // register, which a same-cycle consume also provides.
    assign w_in_ready = !((r_sel == LAST_SLOT) && w_full && !out_ready);
    assign w_in_xfer  = in_valid && w_in_ready;
    assign w_out_xfer = w_full && out_ready;

    // A sync bit always restarts at slot 0, discarding whatever was assembled.
    assign w_slot     = frame_sync ? '0 : r_sel;
    assign w_wr_sel   = LSB_FIRST ? w_slot : (LAST_SLOT - w_slot);
    assign w_complete = w_in_xfer && !frame_sync && (r_sel == LAST_SLOT);

    demux1_to_8 u_demux (
        .i_bit    (in_bit),
        .i_sel    (w_wr_sel),
        .i_en     (w_in_xfer),
        .o_strobe (w_strobe),
        .o_data   (w_data)
    );

    assign w_asm_base = frame_sync ? '0 : r_asm;
    assign w_asm_next = (w_asm_base & ~w_strobe) | w_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel      <= '0;
            r_asm      <= '0;
            r_out      <= '0;
            r_state    <= OUT_EMPTY;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= w_in_xfer && frame_sync && (r_sel != '0);

            if (w_in_xfer) begin
                r_asm <= w_complete ? '0 : w_asm_next;
                r_sel <= frame_sync ? IDX_W'(1) : (r_sel + IDX_W'(1));
            end

            // Completion while FULL can only happen alongside a consume,
            // so loading new data here never overwrites an unread word.
            if (w_complete) begin
                r_out   <= w_asm_next;
                r_state <= OUT_FULL;
            end else if (w_out_xfer) begin
                r_state <= OUT_EMPTY;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out       = r_out;
    assign out_valid = w_full;
    assign sel       = r_sel;
    assign sync_err  = r_sync_err;

endmodule
